systolic_tile_sequencer: RTL and testbench
==========================================

Name: systolic_tile_sequencer

Overview:
Control FSM that runs one output tile (BN_NUM rows x 1 output column) through the SystolicArrayv1 datapath.
- Phases per tile: weight-buffer load, skewed activation streaming, adder-tree drain, result hand-off, accumulator clear.
- Sits between the tile-loop controller (start/done) and the PE array plus its activation/weight buffers.
- Replaces the bench-driven sequencing with synthesizable control.

Parameters:
BN_NUM, 8, number of MAC rows in the array
ACCU_NUM, 4, accumulate lanes (activation skew depth)
K_W, 8, width of k_steps / wet_idx (max reduction chunks 2^K_W-1)
DRAIN_CYC, $clog2(ACCU_NUM)+1, adder-tree drain latency in cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  tile start pulse, sampled only in IDLE
k_steps  in  K_W  number of ACCU_NUM-wide weight chunks, latched on accepted start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at tile completion
wet_load_en  out  1  write strobe to PE weight buffer
wet_idx  out  K_W  weight chunk index, 0..k_steps-1
act_step  out  $clog2(BN_NUM+ACCU_NUM)  skew step s; lane k reads row s-k
act_lane_vld  out  ACCU_NUM  bit k = 1 iff 0 <= s-k < BN_NUM; lanes with bit k = 0 drive 0
pe_mac_enable  out  1  MAC enable to the array
pe_clear_acc  out  1  accumulator clear to the array
result_valid  out  1  PE_result_out is final and must be captured
result_ready  in  1  consumer accepts the result
busy_cycles  out  32  perf counter (see Optional Feature)
stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; every output = 0. Reset also sets counters to 0.
- Reset mid-tile: abort to IDLE on the next edge. No done pulse. pe_clear_acc is not asserted.
- States:
  - IDLE: accept start.
    - k_steps != 0 -> LOAD_W, with the counter at 0.
    - k_steps == 0 -> ZERO, which pulses done for 1 cycle and then returns to IDLE. No datapath strobes.
  - LOAD_W: wet_load_en = 1 and wet_idx = counter for exactly k_steps cycles, counting 0..k_steps-1. Then -> STREAM.
  - STREAM: pe_mac_enable = 1 and act_step = 0..BN_NUM+ACCU_NUM-2, one value per cycle (11 cycles at defaults). act_lane_vld is per the rule above. Then -> DRAIN.
  - DRAIN: DRAIN_CYC cycles with pe_mac_enable = 1 and act_lane_vld = 0. Then -> OUT.
  - OUT: result_valid = 1 and pe_mac_enable = 0. Hold until result_ready = 1 is sampled, then -> CLEAR.
  - CLEAR: pe_clear_acc = 1 and done = 1 for exactly one cycle. Then -> IDLE.
- start outside IDLE is ignored; it is neither queued nor an error.
- A start sampled in the same cycle done is high is ignored, because the FSM is still in CLEAR. The earliest new tile starts from a start sampled one cycle after done.
- result_ready outside OUT is ignored.
- result_valid never drops before the handshake.
- Latency, start sample to done, with result_ready tied high: k_steps + (BN_NUM+ACCU_NUM-1) + DRAIN_CYC + 2 cycles. At defaults with k_steps = 4 this is 20.
- Counter widths:
  - k counter: K_W bits, no wrap, because its terminal count is k_steps-1.
  - step counter: $clog2(BN_NUM+ACCU_NUM) bits.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined:
  - busy_cycles increments every cycle busy = 1.
  - stall_cycles increments every cycle in OUT with result_ready = 0.
  - Both are 32-bit, saturate at 2^32-1, clear only on reset, and are not cleared by start.
- Undefined: both ports are tied to constant 0 and no counter flops are built.

Decomposition:
- Package systolic_pkg holds:
  - state enum seq_state_t {IDLE, ZERO, LOAD_W, STREAM, DRAIN, OUT, CLEAR};
  - localparams STREAM_LEN = BN_NUM+ACCU_NUM-1 and STEP_W = $clog2(STREAM_LEN+1);
  - function lane_valid(step, k), shared with the activation buffer.
- No sub-module. This is a single FSM plus counters. The perf counters sit inline under `ifdef.

Test Plan:
1. Defaults, k_steps = 4, result_ready = 1, start pulse -> wet_idx 0,1,2,3 on 4 cycles; act_step 0..10; act_lane_vld 0001 at step 0, 1111 at steps 3..7, 1000 at step 10; done 20 cycles after start; busy high for those 20 cycles.
2. result_ready held low 5 cycles in OUT -> result_valid stable for 6 cycles; done 25 cycles after start; stall_cycles = 5 with SEQ_PERF_CNT_EN.
3. k_steps = 0 -> done pulses 2 cycles after start; wet_load_en, pe_mac_enable and pe_clear_acc stay 0.
4. Second start pulse during STREAM -> ignored; exactly one done; a start sampled in the cycle after done begins a new tile.
5. reset asserted during DRAIN -> next cycle all outputs 0, state IDLE, no done or pe_clear_acc; a subsequent start runs a full 20-cycle tile.
6. k_steps = 255 (max), back-to-back tiles -> wet_idx reaches 254 with no wrap; busy_cycles equals the sum of the per-tile latencies.

Source files
------------

// File: rtl/systolic_tile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared types and helpers for the systolic tile sequencer.
//                The activation buffer also uses them.
//                  - seq_state_t : sequencer state encoding.
//                  - STREAM_LEN  : skew steps per tile at the default array
//                                  size. STEP_W is the width that holds them.
//                  - lane_valid  : says whether accumulate lane k reads a real
//                                  row at skew step s.
//  Revision    : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int BN_NUM_DEF   = 8;
    localparam int ACCU_NUM_DEF = 4;
    localparam int STREAM_LEN   = BN_NUM_DEF + ACCU_NUM_DEF - 1;
    localparam int STEP_W       = $clog2(STREAM_LEN + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ZERO   = 3'd1,
        LOAD_W = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        OUT    = 3'd5,
        CLEAR  = 3'd6
    } seq_state_t;

    // Lane k reads row (step - k). The row exists only while 0 <= step-k < rows.
    function automatic logic lane_valid(input int step, input int k,
                                        input int rows = BN_NUM_DEF);
        return ((step - k) >= 0) && ((step - k) < rows);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_tile_sequencer
//  Description : Control FSM that runs one output tile (BN_NUM rows x 1
//                column) through the systolic datapath. The phases are weight
//                load, skewed activation streaming, adder-tree drain, result
//                hand-off and accumulator clear. All outputs are registered.
//                Optional build macro: SEQ_PERF_CNT_EN builds the saturating
//                busy and stall performance counters. When it is undefined,
//                both counter ports read 0.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start, k_steps    - tile request; k_steps is latched on accept
//                busy, done        - tile in flight, one-cycle completion pulse
//                wet_load_en/idx   - weight-buffer write strobe and chunk index
//                act_step/lane_vld - skew step and per-lane row-valid mask
//                pe_mac_enable     - MAC enable to the PE array
//                pe_clear_acc      - accumulator clear to the PE array
//                result_valid/ready- result hand-off handshake
//                busy_cycles, stall_cycles - performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_tile_sequencer
    import systolic_pkg::*;
#(
    parameter int BN_NUM    = BN_NUM_DEF,
    parameter int ACCU_NUM  = ACCU_NUM_DEF,
    parameter int K_W       = 8,
    parameter int DRAIN_CYC = $clog2(ACCU_NUM) + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [K_W-1:0]                        k_steps,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  wet_load_en,
    output logic [K_W-1:0]                        wet_idx,
    output logic [$clog2(BN_NUM+ACCU_NUM)-1:0]    act_step,
    output logic [ACCU_NUM-1:0]                   act_lane_vld,
    output logic                                  pe_mac_enable,
    output logic                                  pe_clear_acc,
    output logic                                  result_valid,
    input  logic                                  result_ready,
    output logic [31:0]                           busy_cycles,
    output logic [31:0]                           stall_cycles
);

    localparam int c_STREAM_LEN = BN_NUM + ACCU_NUM - 1;
    localparam int c_ACT_W      = $clog2(BN_NUM + ACCU_NUM);
    localparam logic [c_ACT_W-1:0] c_LAST_STEP  = c_ACT_W'(c_STREAM_LEN - 1);
    localparam logic [K_W-1:0]     c_DRAIN_LAST = K_W'(DRAIN_CYC - 1);

    seq_state_t     r_state;
    logic [K_W-1:0] r_k_cnt;   // weight chunk index, then drain cycle and ZERO phase
    logic [K_W-1:0] r_k_lat;

    function automatic logic [ACCU_NUM-1:0] lane_vec(input int step);
        logic [ACCU_NUM-1:0] v;
        v = '0;
        for (int k = 0; k < ACCU_NUM; k++) begin
            v[k] = lane_valid(step, k, BN_NUM);
        end
        return v;
    endfunction

    // The outputs are computed together with the next state. This way every
    // strobe is valid in the same cycle that the state it belongs to is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_k_cnt       <= '0;
            r_k_lat       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wet_load_en   <= 1'b0;
            wet_idx       <= '0;
            act_step      <= '0;
            act_lane_vld  <= '0;
            pe_mac_enable <= 1'b0;
            pe_clear_acc  <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            done          <= 1'b0;
            wet_load_en   <= 1'b0;
            act_lane_vld  <= '0;
            pe_mac_enable <= 1'b0;
            pe_clear_acc  <= 1'b0;
            result_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_k_lat <= k_steps;
                        r_k_cnt <= '0;
                        if (k_steps == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_state     <= LOAD_W;
                            wet_load_en <= 1'b1;
                            wet_idx     <= '0;
                        end
                    end
                end
                // Takes two cycles: one quiet cycle, then the done pulse. The
                // done pulse therefore comes while busy is still high, the
                // same as at the end of a normal tile.
                ZERO: begin
                    if (r_k_cnt == '0) begin
                        r_k_cnt <= K_W'(1);
                        done    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (r_k_cnt == r_k_lat - 1'b1) begin
                        r_state       <= STREAM;
                        wet_idx       <= '0;
                        act_step      <= '0;
                        act_lane_vld  <= lane_vec(0);
                        pe_mac_enable <= 1'b1;
                    end else begin
                        r_k_cnt     <= r_k_cnt + 1'b1;
                        wet_load_en <= 1'b1;
                        wet_idx     <= r_k_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    pe_mac_enable <= 1'b1;
                    if (act_step == c_LAST_STEP) begin
                        r_state  <= DRAIN;
                        act_step <= '0;
                        r_k_cnt  <= '0;
                    end else begin
                        act_step     <= act_step + 1'b1;
                        act_lane_vld <= lane_vec(int'(act_step) + 1);
                    end
                end
                DRAIN: begin
                    if (r_k_cnt == c_DRAIN_LAST) begin
                        r_state      <= OUT;
                        result_valid <= 1'b1;
                    end else begin
                        r_k_cnt       <= r_k_cnt + 1'b1;
                        pe_mac_enable <= 1'b1;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        r_state      <= CLEAR;
                        pe_clear_acc <= 1'b1;
                        done         <= 1'b1;
                    end else begin
                        result_valid <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_busy_cnt;
    logic [31:0] r_stall_cnt;

    // These counters are cleared only by reset. They keep counting across
    // tiles and stop at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (busy && (r_busy_cnt != '1)) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end
            if ((r_state == OUT) && !result_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign busy_cycles  = r_busy_cnt;
    assign stall_cycles = r_stall_cnt;
`else
    assign busy_cycles  = '0;
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_tile_sequencer
//  Description : Directed self-checking bench for systolic_tile_sequencer
//                at the default parameters.
//                Optional build macro: SEQ_PERF_CNT_EN (changes the expected
//                counter values).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_systolic_tile_sequencer;

    localparam int K_W = 8;
    localparam int AN  = 4;
    localparam int AW  = 4;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [K_W-1:0] k_steps;
    logic           result_ready;
    logic           busy, done, wet_load_en;
    logic [K_W-1:0] wet_idx;
    logic [AW-1:0]  act_step;
    logic [AN-1:0]  act_lane_vld;
    logic           pe_mac_enable, pe_clear_acc, result_valid;
    logic [31:0]    busy_cycles, stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_busy  = 0;
    int exp_stall = 0;

    // Lane masks for skew steps 0..10 (8 rows, 4 lanes), worked out by hand.
    logic [3:0] lane_tab [0:10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000};

    always #5 clk = ~clk;

    systolic_tile_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .k_steps       (k_steps),
        .busy          (busy),
        .done          (done),
        .wet_load_en   (wet_load_en),
        .wet_idx       (wet_idx),
        .act_step      (act_step),
        .act_lane_vld  (act_lane_vld),
        .pe_mac_enable (pe_mac_enable),
        .pe_clear_acc  (pe_clear_acc),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .busy_cycles   (busy_cycles),
        .stall_cycles  (stall_cycles)
    );

    // Drives a one-cycle start pulse. On return, the sampling edge has just passed.
    task automatic pulse_start(input int k);
        @(negedge clk);
        k_steps = K_W'(k);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the number of cycles from the start sample to done, or -1 on timeout.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; k_steps = 8'd4; result_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({done, wet_load_en, pe_mac_enable, pe_clear_acc, result_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000",
                               {done, wet_load_en, pe_mac_enable, pe_clear_acc, result_valid}); end
        checks++; if ({wet_idx, act_step, act_lane_vld} !== 16'h0) begin
            errors++; $display("FAIL reset_buses got=%h exp=0000", {wet_idx, act_step, act_lane_vld}); end
        checks++; if ({busy_cycles, stall_cycles} !== 64'h0) begin
            errors++; $display("FAIL reset_counters got=%h exp=0", {busy_cycles, stall_cycles}); end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic;
        bit exp_wle, exp_mac;
        pulse_start(4);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            exp_wle = (c >= 1 && c <= 4);
            exp_mac = (c >= 5 && c <= 18);
            checks++; if (wet_load_en !== exp_wle) begin errors++;
                $display("FAIL basic_wet_load_en cyc=%0d got=%b exp=%b", c, wet_load_en, exp_wle); end
            if (exp_wle) begin
                checks++; if (wet_idx !== K_W'(c - 1)) begin errors++;
                    $display("FAIL basic_wet_idx cyc=%0d got=%0d exp=%0d", c, wet_idx, c - 1); end
            end
            checks++; if (pe_mac_enable !== exp_mac) begin errors++;
                $display("FAIL basic_mac cyc=%0d got=%b exp=%b", c, pe_mac_enable, exp_mac); end
            if (c >= 5 && c <= 15) begin
                checks++; if (act_step !== AW'(c - 5)) begin errors++;
                    $display("FAIL basic_act_step cyc=%0d got=%0d exp=%0d", c, act_step, c - 5); end
                checks++; if (act_lane_vld !== lane_tab[c - 5]) begin errors++;
                    $display("FAIL basic_lanes step=%0d got=%b exp=%b", c - 5, act_lane_vld, lane_tab[c - 5]); end
            end
            if (c >= 16 && c <= 18) begin
                checks++; if (act_lane_vld !== 4'b0000) begin errors++;
                    $display("FAIL basic_drain_lanes cyc=%0d got=%b exp=0000", c, act_lane_vld); end
            end
            checks++; if (result_valid !== (c == 19)) begin errors++;
                $display("FAIL basic_result_valid cyc=%0d got=%b exp=%b", c, result_valid, c == 19); end
            checks++; if (done !== (c == 20) || pe_clear_acc !== (c == 20)) begin errors++;
                $display("FAIL basic_done_clear cyc=%0d got=%b%b exp=%b%b", c, done, pe_clear_acc, c == 20, c == 20); end
            checks++; if (busy !== (c <= 20)) begin errors++;
                $display("FAIL basic_busy cyc=%0d got=%b exp=%b", c, busy, c <= 20); end
        end
        exp_busy += 20;
        checks++; if (busy_cycles !== (PERF ? 32'(exp_busy) : 32'd0)) begin errors++;
            $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cycles, PERF ? exp_busy : 0); end
    endtask

    task automatic test_stall;
        int lat, rv_cnt;
        result_ready = 1'b0;
        pulse_start(4);
        lat = -1; rv_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (result_valid === 1'b1) rv_cnt++;
            if (done === 1'b1) begin lat = c; break; end
            if (rv_cnt == 6) result_ready = 1'b1;
        end
        checks++; if (lat != 25) begin errors++; $display("FAIL stall_latency got=%0d exp=25", lat); end
        checks++; if (rv_cnt != 6) begin errors++; $display("FAIL stall_valid_cycles got=%0d exp=6", rv_cnt); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_after got=%b exp=0", result_valid); end
        result_ready = 1'b1;
        exp_busy += 25; exp_stall = 5;
        checks++; if (stall_cycles !== (PERF ? 32'(exp_stall) : 32'd0)) begin errors++;
            $display("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, PERF ? exp_stall : 0); end
    endtask

    task automatic test_zero;
        int lat, ndone;
        bit strobe;
        pulse_start(0);
        lat = -1; ndone = 0; strobe = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (wet_load_en | pe_mac_enable | pe_clear_acc | result_valid) strobe = 1'b1;
            if (done === 1'b1) begin ndone++; if (lat < 0) lat = c; end
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL zero_latency got=%0d exp=2", lat); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", ndone); end
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL zero_strobes got=%b exp=0", strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
        exp_busy += 2;
        checks++; if (busy_cycles !== (PERF ? 32'(exp_busy) : 32'd0)) begin errors++;
            $display("FAIL zero_busy_cycles got=%0d exp=%0d", busy_cycles, PERF ? exp_busy : 0); end
    endtask

    task automatic test_ignore_start;
        int lat, lat2, nd;
        pulse_start(4);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 8) begin k_steps = 8'd4; start = 1'b1; end
            else start = 1'b0;
            if (done === 1'b1) begin lat = c; break; end
        end
        checks++; if (lat != 20) begin errors++; $display("FAIL ignore_latency got=%0d exp=20", lat); end
        // Hold start through the done cycle and the cycle after it. Only the
        // second sample may be accepted.
        start = 1'b1; k_steps = 8'd4;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL ignore_done_cycle_start got=%b%b exp=00", busy, done); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40, lat2);
        checks++; if (lat2 != 20) begin errors++; $display("FAIL ignore_next_latency got=%0d exp=20", lat2); end
        nd = 0;
        repeat (25) begin @(negedge clk); if (done === 1'b1) nd++; end
        checks++; if (nd != 0) begin errors++; $display("FAIL ignore_extra_done got=%0d exp=0", nd); end
        exp_busy += 40;
        checks++; if (busy_cycles !== (PERF ? 32'(exp_busy) : 32'd0)) begin errors++;
            $display("FAIL ignore_busy_cycles got=%0d exp=%0d", busy_cycles, PERF ? exp_busy : 0); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit bad;
        pulse_start(4);
        repeat (16) @(negedge clk);
        checks++; if (pe_mac_enable !== 1'b1 || act_lane_vld !== 4'b0000) begin errors++;
            $display("FAIL midrst_in_drain got=%b/%b exp=1/0000", pe_mac_enable, act_lane_vld); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, wet_load_en, pe_mac_enable, pe_clear_acc, result_valid} !== 6'b0) begin
            errors++; $display("FAIL midrst_outputs got=%b exp=000000",
                {busy, done, wet_load_en, pe_mac_enable, pe_clear_acc, result_valid}); end
        checks++; if ({wet_idx, act_step, act_lane_vld, busy_cycles, stall_cycles} !== 80'h0) begin
            errors++; $display("FAIL midrst_buses got=%h exp=0",
                {wet_idx, act_step, act_lane_vld, busy_cycles, stall_cycles}); end
        bad = 1'b0;
        repeat (25) begin @(negedge clk); if (done | pe_clear_acc | busy) bad = 1'b1; end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b exp=0", bad); end
        exp_busy = 0; exp_stall = 0;
        pulse_start(4);
        wait_done(40, lat);
        checks++; if (lat != 20) begin errors++; $display("FAIL midrst_restart_latency got=%0d exp=20", lat); end
        exp_busy += 20;
        @(negedge clk);
        checks++; if (busy_cycles !== (PERF ? 32'(exp_busy) : 32'd0)) begin errors++;
            $display("FAIL midrst_busy_cycles got=%0d exp=%0d", busy_cycles, PERF ? exp_busy : 0); end
    endtask

    task automatic test_back_to_back;
        int lat, lat2, nload, max_idx, seq_err;
        pulse_start(255);
        lat = -1; nload = 0; max_idx = 0; seq_err = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (wet_load_en === 1'b1) begin
                if (wet_idx !== K_W'(nload)) seq_err++;
                if (int'(wet_idx) > max_idx) max_idx = int'(wet_idx);
                nload++;
            end
            if (done === 1'b1) begin lat = c; break; end
        end
        checks++; if (lat != 271) begin errors++; $display("FAIL b2b_latency1 got=%0d exp=271", lat); end
        checks++; if (nload != 255) begin errors++; $display("FAIL b2b_load_cycles got=%0d exp=255", nload); end
        checks++; if (max_idx != 254) begin errors++; $display("FAIL b2b_max_wet_idx got=%0d exp=254", max_idx); end
        checks++; if (seq_err != 0) begin errors++; $display("FAIL b2b_wet_idx_sequence got=%0d exp=0", seq_err); end
        pulse_start(255);
        wait_done(400, lat2);
        checks++; if (lat2 != 271) begin errors++; $display("FAIL b2b_latency2 got=%0d exp=271", lat2); end
        exp_busy += 542;
        @(negedge clk);
        checks++; if (busy_cycles !== (PERF ? 32'(exp_busy) : 32'd0)) begin errors++;
            $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cycles, PERF ? exp_busy : 0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; k_steps = '0; result_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
